change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 34 +++
 rtl/change_dispenser_eject_timer.sv | 25 ++
 rtl/change_dispenser.sv | 137 +++++++++++++
 tb/tb_change_dispenser.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared vending constants: money width, coin values, FSM encoding
package change_dispenser_pkg;

    localparam int MONEY_W = 8;
    typedef logic [MONEY_W-1:0] money_t;

    localparam money_t QUARTER_VAL = 8'd25;
    localparam money_t FIFTY_VAL   = 8'd50;
    localparam money_t DOLLAR_VAL  = 8'd100;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_SELECT = 3'd1;
    localparam logic [STATE_W-1:0] ST_PULSE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAP    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_QUARTER = 2'd1,
        COIN_FIFTY   = 2'd2,
        COIN_DOLLAR  = 2'd3
    } coin_e;

    function automatic money_t coin_value(input coin_e coin);
        case (coin)
            COIN_QUARTER: return QUARTER_VAL;
            COIN_FIFTY:   return FIFTY_VAL;
            COIN_DOLLAR:  return DOLLAR_VAL;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_eject_timer.sv
// rtl/change_dispenser_eject_timer.sv - loadable down-counter timing eject pulses and gaps
module eject_timer (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] r_count;

    // Saturates at zero so it can free-run between loads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change dispenser with per-tube inventory
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int          PULSE_CYCLES = 4,
    parameter int          GAP_CYCLES   = 4,
    parameter logic [7:0]  TUBE_FULL    = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [7:0] change_amount,
    output logic       change_ready,
    input  logic       restock,
    output logic       eject_quarter,
    output logic       eject_fifty,
    output logic       eject_dollar,
    output logic       busy,
    output logic       done,
    output logic       short_err,
    output logic [7:0] shortfall,
    output logic [7:0] quarter_cnt,
    output logic [7:0] fifty_cnt,
    output logic [7:0] dollar_cnt
);

    logic [STATE_W-1:0] r_state;
    money_t             r_remaining;
    money_t             r_quarter_cnt;
    money_t             r_fifty_cnt;
    money_t             r_dollar_cnt;
    coin_e              r_coin;
    logic               r_short_err;
    money_t             r_shortfall;

    coin_e              w_coin;
    logic               w_timer_load;
    logic [7:0]         w_timer_val;
    logic               w_timer_zero;

    // Compare before subtract: the chosen coin never exceeds what is owed.
    always_comb begin
        w_coin = COIN_NONE;
        if (r_remaining >= DOLLAR_VAL && r_dollar_cnt != '0) begin
            w_coin = COIN_DOLLAR;
        end else if (r_remaining >= FIFTY_VAL && r_fifty_cnt != '0) begin
            w_coin = COIN_FIFTY;
        end else if (r_remaining >= QUARTER_VAL && r_quarter_cnt != '0) begin
            w_coin = COIN_QUARTER;
        end
    end

    always_comb begin
        w_timer_load = 1'b0;
        w_timer_val  = '0;
        if (r_state == ST_SELECT && w_coin != COIN_NONE) begin
            w_timer_load = 1'b1;
            w_timer_val  = 8'(PULSE_CYCLES - 1);
        end else if (r_state == ST_PULSE && w_timer_zero) begin
            w_timer_load = 1'b1;
            w_timer_val  = 8'(GAP_CYCLES - 1);
        end
    end

    eject_timer u_eject_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_quarter_cnt <= TUBE_FULL;
            r_fifty_cnt   <= TUBE_FULL;
            r_dollar_cnt  <= TUBE_FULL;
            r_coin        <= COIN_NONE;
            r_short_err   <= 1'b0;
            r_shortfall   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (restock) begin
                        r_quarter_cnt <= TUBE_FULL;
                        r_fifty_cnt   <= TUBE_FULL;
                        r_dollar_cnt  <= TUBE_FULL;
                    end
                    if (change_valid) begin
                        r_remaining <= change_amount;
                        r_short_err <= 1'b0;
                        r_shortfall <= '0;
                        r_state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    case (w_coin)
                        COIN_DOLLAR:  r_dollar_cnt  <= r_dollar_cnt - 8'd1;
                        COIN_FIFTY:   r_fifty_cnt   <= r_fifty_cnt - 8'd1;
                        COIN_QUARTER: r_quarter_cnt <= r_quarter_cnt - 8'd1;
                        default: ;
                    endcase
                    if (w_coin != COIN_NONE) begin
                        r_remaining <= r_remaining - coin_value(w_coin);
                        r_coin      <= w_coin;
                        r_state     <= ST_PULSE;
                    end else begin
                        r_state <= ST_DONE;
                        if (r_remaining != '0) begin
                            r_short_err <= 1'b1;
                            r_shortfall <= r_remaining;
                        end
                    end
                end
                ST_PULSE: if (w_timer_zero) r_state <= ST_GAP;
                ST_GAP:   if (w_timer_zero) r_state <= ST_SELECT;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign change_ready  = (r_state == ST_IDLE);
    assign busy          = (r_state == ST_SELECT) || (r_state == ST_PULSE) || (r_state == ST_GAP);
    assign done          = (r_state == ST_DONE);
    assign eject_quarter = (r_state == ST_PULSE) && (r_coin == COIN_QUARTER);
    assign eject_fifty   = (r_state == ST_PULSE) && (r_coin == COIN_FIFTY);
    assign eject_dollar  = (r_state == ST_PULSE) && (r_coin == COIN_DOLLAR);
    assign short_err     = r_short_err;
    assign shortfall     = r_shortfall;
    assign quarter_cnt   = r_quarter_cnt;
    assign fifty_cnt     = r_fifty_cnt;
    assign dollar_cnt    = r_dollar_cnt;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser
module tb_change_dispenser;

    localparam int P    = 4;
    localparam int G    = 4;
    localparam int SLOT = P + G + 1;
    localparam int FULL = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = '0;
    logic       restock = 1'b0;
    logic       change_ready, eject_quarter, eject_fifty, eject_dollar;
    logic       busy, done, short_err;
    logic [7:0] shortfall, quarter_cnt, fifty_cnt, dollar_cnt;

    int checks = 0;
    int errors = 0;
    int m_q = FULL, m_f = FULL, m_d = FULL;

    always #5 clk = ~clk;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .TUBE_FULL(8'd20)) dut (
        .clk(clk), .reset(reset), .change_valid(change_valid), .change_amount(change_amount),
        .change_ready(change_ready), .restock(restock), .eject_quarter(eject_quarter),
        .eject_fifty(eject_fifty), .eject_dollar(eject_dollar), .busy(busy), .done(done),
        .short_err(short_err), .shortfall(shortfall), .quarter_cnt(quarter_cnt),
        .fifty_cnt(fifty_cnt), .dollar_cnt(dollar_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        change_valid = 1'b0;
        restock = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_q = FULL; m_f = FULL; m_d = FULL;
    endtask

    // One request: greedy model gives the coin list; timing follows from one slot per coin.
    task automatic run_request(input int amount, input bit rs_accept, input bit noise);
        int coins[$];
        int rem, k_done, pre_q, pre_f, pre_d;
        bit go;
        logic [2:0] exp_ej, obs_ej;
        @(negedge clk);
        checks++;
        if (change_ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle amt=%0d got=%b exp=1", amount, change_ready);
        end
        change_valid  = 1'b1;
        change_amount = amount[7:0];
        restock       = rs_accept;
        if (rs_accept) begin m_q = FULL; m_f = FULL; m_d = FULL; end
        pre_q = m_q; pre_f = m_f; pre_d = m_d;
        rem = amount;
        go = 1'b1;
        while (go) begin
            if (rem >= 100 && m_d > 0) begin coins.push_back(100); rem -= 100; m_d--; end
            else if (rem >= 50 && m_f > 0) begin coins.push_back(50); rem -= 50; m_f--; end
            else if (rem >= 25 && m_q > 0) begin coins.push_back(25); rem -= 25; m_q--; end
            else go = 1'b0;
        end
        k_done = 2 + coins.size() * SLOT;
        @(posedge clk);
        for (int k = 1; k <= k_done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({dollar_cnt, fifty_cnt, quarter_cnt} !== {pre_d[7:0], pre_f[7:0], pre_q[7:0]}) begin
                    errors++; $display("FAIL counts_select amt=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                        amount, dollar_cnt, fifty_cnt, quarter_cnt, pre_d, pre_f, pre_q);
                end
                checks++;
                if (short_err !== 1'b0 || shortfall !== 8'd0) begin
                    errors++; $display("FAIL clear_on_accept amt=%0d got=%b/%0d exp=0/0", amount, short_err, shortfall);
                end
            end
            exp_ej = 3'b000;
            foreach (coins[i]) begin
                if (k >= 2 + i * SLOT && k < 2 + i * SLOT + P)
                    exp_ej = (coins[i] == 100) ? 3'b100 : (coins[i] == 50) ? 3'b010 : 3'b001;
            end
            obs_ej = {eject_dollar, eject_fifty, eject_quarter};
            checks++;
            if (obs_ej !== exp_ej) begin
                errors++; $display("FAIL eject amt=%0d cycle=%0d got=%b exp=%b", amount, k, obs_ej, exp_ej);
            end
            checks++;
            if (done !== 1'(k == k_done)) begin
                errors++; $display("FAIL done amt=%0d cycle=%0d got=%b exp=%b", amount, k, done, k == k_done);
            end
            checks++;
            if (busy !== 1'(k < k_done)) begin
                errors++; $display("FAIL busy amt=%0d cycle=%0d got=%b exp=%b", amount, k, busy, k < k_done);
            end
            if (k == k_done) begin
                checks++;
                if (short_err !== 1'(rem != 0) || shortfall !== rem[7:0]) begin
                    errors++; $display("FAIL short amt=%0d got=%b/%0d exp=%b/%0d",
                        amount, short_err, shortfall, rem != 0, rem);
                end
            end
            if (noise && k < k_done) begin
                change_valid  = 1'b1;
                change_amount = 8'($urandom_range(0, 255));
                restock       = 1'b1;
            end else begin
                change_valid = 1'b0;
                restock      = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (change_ready !== 1'b1 || {dollar_cnt, fifty_cnt, quarter_cnt} !== {m_d[7:0], m_f[7:0], m_q[7:0]}) begin
            errors++; $display("FAIL after_done amt=%0d ready=%b got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                amount, change_ready, dollar_cnt, fifty_cnt, quarter_cnt, m_d, m_f, m_q);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; change_valid = 1'b1; change_amount = 8'd100; restock = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0; change_valid = 1'b0; restock = 1'b0;
        m_q = FULL; m_f = FULL; m_d = FULL;
        checks++;
        if ({change_ready, busy, done, eject_dollar, eject_fifty, eject_quarter, short_err} !== 7'b1000000) begin
            errors++; $display("FAIL reset_flags got=%b exp=1000000",
                {change_ready, busy, done, eject_dollar, eject_fifty, eject_quarter, short_err});
        end
        checks++;
        if ({shortfall, dollar_cnt, fifty_cnt, quarter_cnt} !== {8'd0, 8'd20, 8'd20, 8'd20}) begin
            errors++; $display("FAIL reset_values got=%0d/%0d/%0d/%0d exp=0/20/20/20",
                shortfall, dollar_cnt, fifty_cnt, quarter_cnt);
        end
    endtask

    task automatic test_basic();
        run_request(75, 1'b0, 1'b0);
        checks++;
        if (fifty_cnt !== 8'd19 || quarter_cnt !== 8'd19) begin
            errors++; $display("FAIL cnt_75 got=%0d/%0d exp=19/19", fifty_cnt, quarter_cnt);
        end
        run_request(175, 1'b0, 1'b0);
        run_request(0, 1'b0, 1'b0);
        run_request(110, 1'b0, 1'b0);
        run_request(26, 1'b0, 1'b0);
        run_request(24, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_pulse();
        int done_seen;
        do_reset();
        @(negedge clk);
        change_valid = 1'b1; change_amount = 8'd50;
        @(posedge clk);
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (eject_fifty !== 1'b1) begin
            errors++; $display("FAIL mid_pulse_active got=%b exp=1", eject_fifty);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({eject_dollar, eject_fifty, eject_quarter, change_ready, busy, done} !== 6'b000100 ||
            {dollar_cnt, fifty_cnt, quarter_cnt} !== {8'd20, 8'd20, 8'd20}) begin
            errors++; $display("FAIL mid_pulse_reset got=%b cnt=%0d/%0d/%0d exp=000100 20/20/20",
                {eject_dollar, eject_fifty, eject_quarter, change_ready, busy, done},
                dollar_cnt, fifty_cnt, quarter_cnt);
        end
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++; $display("FAIL abandoned_request got=%0d exp=0", done_seen);
        end
    endtask

    task automatic test_depleted();
        do_reset();
        repeat (10) run_request(250, 1'b0, 1'b0);
        repeat (5) run_request(100, 1'b0, 1'b0);
        run_request(250, 1'b0, 1'b0);
        run_request(225, 1'b0, 1'b0);
        checks++;
        if ({dollar_cnt, fifty_cnt, quarter_cnt} !== {8'd0, 8'd0, 8'd1}) begin
            errors++; $display("FAIL depleted got=%0d/%0d/%0d exp=0/0/1", dollar_cnt, fifty_cnt, quarter_cnt);
        end
        run_request(100, 1'b0, 1'b0);
        checks++;
        if (shortfall !== 8'd75 || quarter_cnt !== 8'd0) begin
            errors++; $display("FAIL short_75 got=%0d/%0d exp=75/0", shortfall, quarter_cnt);
        end
    endtask

    task automatic test_restock();
        run_request(25, 1'b1, 1'b0);
        checks++;
        if (quarter_cnt !== 8'd19 || dollar_cnt !== 8'd20) begin
            errors++; $display("FAIL restock_accept got=%0d/%0d exp=19/20", quarter_cnt, dollar_cnt);
        end
        run_request(100, 1'b0, 1'b1);
        checks++;
        if (dollar_cnt !== 8'd19 || quarter_cnt !== 8'd19) begin
            errors++; $display("FAIL restock_busy got=%0d/%0d exp=19/19", dollar_cnt, quarter_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_request(150, 1'b0, 1'b1);
        run_request(85, 1'b0, 1'b1);
        run_request(0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        repeat (25) begin
            run_request(int'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_pulse();
        test_depleted();
        test_restock();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
